fetch_issue_unit: RTL and testbench

- Producer side of the decode stage's input interface.
- Accepts one aligned fetch line of `instsPerLine` instructions, plus its PID/TID/64-bit context, from the fetch/cache path.
- Presents one instruction per cycle to `DecodeUnit`, along with its address and a monotonically increasing major instruction ID.
- Honours the decoder's stall and supports pipeline flush.

---
 rtl/fetch_issue_if.sv | 60 ++++++
 rtl/fetch_issue_unit.sv | 127 ++++++++++++
 tb/tb_fetch_issue_unit.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_issue_if.sv
// Bundles the fetch-line handshake and the decoder-facing outputs of the
// fetch issue unit. The master side is the unit; the slave side is the
// fetch path plus the decoder. The optional littleEndian_i line exists only
// when FETCH_LE_SWAP_EN is defined. All vectors use big-endian bit numbering.
//
// Handshake: a line moves from source to unit on a rising edge where
// lineValid_i && lineReady_o; the source holds the line stable until then.
// An instruction moves to the decoder on a rising edge where
// enable_o && !stall_i.
interface fetch_issue_if #(
  parameter int addressWidth            = 64,
  parameter int instructionWidth        = 32,
  parameter int instsPerLine            = 4,
  parameter int PidSize                 = 20,
  parameter int TidSize                 = 16,
  parameter int instructionCounterWidth = 64
);
  logic                                       lineValid_i;
  logic                                       lineReady_o;
  logic [0:instsPerLine*instructionWidth-1]   lineData_i;
  logic [0:addressWidth-1]                    lineAddress_i;
  logic                                       is64Bit_i;
  logic [0:PidSize-1]                         linePid_i;
  logic [0:TidSize-1]                         lineTid_i;
`ifdef FETCH_LE_SWAP_EN
  logic                                       littleEndian_i;
`endif
  logic                                       stall_i;
  logic                                       enable_o;
  logic [0:instructionWidth-1]                instruction_o;
  logic [0:addressWidth-1]                    instructionAddress_o;
  logic                                       is64Bit_o;
  logic [0:PidSize-1]                         instructionPid_o;
  logic [0:TidSize-1]                         instructionTid_o;
  logic [0:instructionCounterWidth-1]         instructionMajId_o;
  // Debug view of the unit's state (0 = EMPTY, 1 = ISSUING).
  logic                                       state_dbg;

  modport master (
    input  lineValid_i, lineData_i, lineAddress_i, is64Bit_i, linePid_i,
           lineTid_i, stall_i,
`ifdef FETCH_LE_SWAP_EN
    input  littleEndian_i,
`endif
    output lineReady_o, enable_o, instruction_o, instructionAddress_o,
           is64Bit_o, instructionPid_o, instructionTid_o, instructionMajId_o,
           state_dbg
  );

  modport slave (
    output lineValid_i, lineData_i, lineAddress_i, is64Bit_i, linePid_i,
           lineTid_i, stall_i,
`ifdef FETCH_LE_SWAP_EN
    output littleEndian_i,
`endif
    input  lineReady_o, enable_o, instruction_o, instructionAddress_o,
           is64Bit_o, instructionPid_o, instructionTid_o, instructionMajId_o,
           state_dbg
  );
endinterface

// File: rtl/fetch_issue_unit.sv
// Fetch issue unit: takes one aligned fetch line and hands its instructions
// to the decoder one per cycle, starting at the slot named by the line
// address, tagging each with its address and a running major ID.
// Optional feature macro: FETCH_LE_SWAP_EN (per-line byte-reversed issue).
module fetch_issue_unit #(
  parameter int addressWidth            = 64,
  parameter int instructionWidth        = 32,
  parameter int instsPerLine            = 4,
  parameter int PidSize                 = 20,
  parameter int TidSize                 = 16,
  parameter int instructionCounterWidth = 64
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          flush_i,
  fetch_issue_if.master bus
);
  localparam int O = $clog2(instsPerLine);
  localparam logic [O-1:0] IDX_LAST = O'(instsPerLine - 1);

  typedef enum logic {EMPTY = 1'b0, ISSUING = 1'b1} state_t;

  state_t                             state_q, state_n;
  logic [O-1:0]                       idx_q, idx_n;
  logic [0:instructionCounterWidth-1] cnt_q, cnt_n;
  logic [0:instructionWidth-1]        slot_q [instsPerLine];
  logic [0:addressWidth-3-O]          base_q;
  logic                               is64_q;
  logic [0:PidSize-1]                 pid_q;
  logic [0:TidSize-1]                 tid_q;
`ifdef FETCH_LE_SWAP_EN
  logic                               le_q;
`endif

  logic         consume;
  logic         last;
  logic         line_ready;
  logic         load;
  logic [O-1:0] start_slot;
  // The two lowest address bits are byte offsets within a word and ignored.
  logic         unused_addr_bits;

  assign start_slot       = bus.lineAddress_i[addressWidth-2-O : addressWidth-3];
  assign unused_addr_bits = ^bus.lineAddress_i[addressWidth-2 : addressWidth-1];
  assign consume          = (state_q == ISSUING) && !bus.stall_i;
  assign last             = (idx_q == IDX_LAST);
  // Accepting on the last-slot consume lets back-to-back lines issue with no bubble.
  assign line_ready       = !flush_i && ((state_q == EMPTY) || (consume && last));
  assign load             = bus.lineValid_i && line_ready;

  // Next-state logic: flush beats load, load beats the last-slot EMPTY move.
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    cnt_n   = cnt_q;
    if (flush_i) begin
      state_n = EMPTY;
    end else begin
      if (consume) begin
        cnt_n = cnt_q + 1'b1;
        if (last) state_n = EMPTY;
        else      idx_n   = idx_q + 1'b1;
      end
      if (load) begin
        state_n = ISSUING;
        idx_n   = start_slot;
      end
    end
  end

  // State, slot index and major ID counter.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= EMPTY;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      cnt_q   <= cnt_n;
    end
  end

  // Line buffer and context capture; kept when going EMPTY.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int k = 0; k < instsPerLine; k++) slot_q[k] <= '0;
      base_q <= '0;
      is64_q <= 1'b0;
      pid_q  <= '0;
      tid_q  <= '0;
`ifdef FETCH_LE_SWAP_EN
      le_q   <= 1'b0;
`endif
    end else if (load) begin
      for (int k = 0; k < instsPerLine; k++)
        slot_q[k] <= bus.lineData_i[k*instructionWidth +: instructionWidth];
      base_q <= bus.lineAddress_i[0 : addressWidth-3-O];
      is64_q <= bus.is64Bit_i;
      pid_q  <= bus.linePid_i;
      tid_q  <= bus.lineTid_i;
`ifdef FETCH_LE_SWAP_EN
      le_q   <= bus.littleEndian_i;
`endif
    end
  end

  // Instruction select; byte reversal applies only to little-endian lines.
  always_comb begin
    bus.instruction_o = slot_q[idx_q];
`ifdef FETCH_LE_SWAP_EN
    if (le_q) begin
      for (int b = 0; b < instructionWidth/8; b++)
        bus.instruction_o[8*b +: 8] = slot_q[idx_q][instructionWidth-8-8*b +: 8];
    end
`endif
  end

  assign bus.lineReady_o          = line_ready;
  assign bus.enable_o             = (state_q == ISSUING);
  assign bus.instructionAddress_o = {base_q, idx_q, 2'b00};
  assign bus.is64Bit_o            = is64_q;
  assign bus.instructionPid_o     = pid_q;
  assign bus.instructionTid_o     = tid_q;
  assign bus.instructionMajId_o   = cnt_q;
  assign bus.state_dbg            = state_q;
endmodule

// File: tb/tb_fetch_issue_unit.sv
// Directed bench for fetch_issue_unit: linear sequence of steps with
// hand-computed expected values, checked by immediate assertions.
module tb_fetch_issue_unit;
  logic clk;
  logic rst_n;
  logic flush;
  int   vectors;
  int   errors;

  fetch_issue_if bus ();

  fetch_issue_unit dut (
    .clock_i (clk),
    .reset_i (rst_n),
    .flush_i (flush),
    .bus     (bus)
  );

  // Clock: posedges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [127:0] data, input logic [63:0] addr);
    bus.lineValid_i   = 1'b1;
    bus.lineData_i    = data;
    bus.lineAddress_i = addr;
  endtask

  task automatic chk_issue(input string tag, input logic [31:0] ins,
                           input logic [63:0] addr, input logic [63:0] id);
    chk({tag, ".en"},   64'(bus.enable_o), 64'd1);
    chk({tag, ".ins"},  64'(bus.instruction_o), 64'(ins));
    chk({tag, ".addr"}, 64'(bus.instructionAddress_o), addr);
    chk({tag, ".id"},   64'(bus.instructionMajId_o), id);
  endtask

  localparam logic [127:0] L1 = {32'h7C221A14, 32'h38210004, 32'h4E800020, 32'h60000000};
  localparam logic [127:0] L2 = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
  localparam logic [127:0] LA = {32'hA0000000, 32'hA1111111, 32'hA2222222, 32'hA3333333};
  localparam logic [127:0] LB = {32'hB0000000, 32'hB1111111, 32'hB2222222, 32'hB3333333};

  initial begin
    vectors = 0;
    errors  = 0;
    rst_n   = 1'b1;
    flush   = 1'b0;
    bus.lineValid_i   = 1'b0;
    bus.lineData_i    = '0;
    bus.lineAddress_i = '0;
    bus.is64Bit_i     = 1'b1;
    bus.linePid_i     = 20'h12345;
    bus.lineTid_i     = 16'hBEEF;
    bus.stall_i       = 1'b0;
`ifdef FETCH_LE_SWAP_EN
    bus.littleEndian_i = 1'b0;
`endif

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst.en",   64'(bus.enable_o), 64'd0);
    chk("rst.id",   64'(bus.instructionMajId_o), 64'd0);
    chk("rst.ins",  64'(bus.instruction_o), 64'd0);
    chk("rst.addr", 64'(bus.instructionAddress_o), 64'd0);
    chk("rst.pid",  64'(bus.instructionPid_o), 64'd0);
    #9 rst_n = 1'b1;
    #1;
    chk("rst.ready", 64'(bus.lineReady_o), 64'd1);

    // 1: full line at 0x1000
    tick();
    offer(L1, 64'h1000);
    #1 chk("t1.ready", 64'(bus.lineReady_o), 64'd1);
    tick();
    bus.lineValid_i = 1'b0;
    chk_issue("t1.s0", 32'h7C221A14, 64'h1000, 64'd0);
    chk("t1.pid", 64'(bus.instructionPid_o), 64'h12345);
    chk("t1.tid", 64'(bus.instructionTid_o), 64'hBEEF);
    chk("t1.is64", 64'(bus.is64Bit_o), 64'd1);
    tick(); chk_issue("t1.s1", 32'h38210004, 64'h1004, 64'd1);
    tick(); chk_issue("t1.s2", 32'h4E800020, 64'h1008, 64'd2);
    tick(); chk_issue("t1.s3", 32'h60000000, 64'h100C, 64'd3);
    chk("t1.ready_last", 64'(bus.lineReady_o), 64'd1);
    tick();
    chk("t1.en_done", 64'(bus.enable_o), 64'd0);
    chk("t1.ready_done", 64'(bus.lineReady_o), 64'd1);

    // 2: mid-line start at 0x2008
    offer(L2, 64'h2008);
    tick();
    bus.lineValid_i = 1'b0;
    chk_issue("t2.s2", 32'h33333333, 64'h2008, 64'd4);
    tick(); chk_issue("t2.s3", 32'h44444444, 64'h200C, 64'd5);
    tick(); chk("t2.en_done", 64'(bus.enable_o), 64'd0);

    // 3: stall for 3 cycles on slot 1
    offer(L1, 64'h3000);
    tick();
    bus.lineValid_i = 1'b0;
    chk_issue("t3.s0", 32'h7C221A14, 64'h3000, 64'd6);
    tick();
    chk_issue("t3.s1", 32'h38210004, 64'h3004, 64'd7);
    bus.stall_i = 1'b1;
    #1 chk("t3.ready_stall", 64'(bus.lineReady_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_issue("t3.hold", 32'h38210004, 64'h3004, 64'd7);
    end
    bus.stall_i = 1'b0;
    tick(); chk_issue("t3.s2", 32'h4E800020, 64'h3008, 64'd8);
    tick(); chk_issue("t3.s3", 32'h60000000, 64'h300C, 64'd9);
    tick(); chk("t3.en_done", 64'(bus.enable_o), 64'd0);

    // 4: back-to-back lines with lineValid held
    offer(LA, 64'h4000);
    tick();
    chk_issue("t4.a0", 32'hA0000000, 64'h4000, 64'd10);
    offer(LB, 64'h5004);
    #1 chk("t4.ready_mid", 64'(bus.lineReady_o), 64'd0);
    tick(); chk_issue("t4.a1", 32'hA1111111, 64'h4004, 64'd11);
    tick(); chk_issue("t4.a2", 32'hA2222222, 64'h4008, 64'd12);
    tick(); chk_issue("t4.a3", 32'hA3333333, 64'h400C, 64'd13);
    chk("t4.ready_last", 64'(bus.lineReady_o), 64'd1);
    tick();
    bus.lineValid_i = 1'b0;
    chk_issue("t4.b1", 32'hB1111111, 64'h5004, 64'd14);
    tick(); chk_issue("t4.b2", 32'hB2222222, 64'h5008, 64'd15);
    tick(); chk_issue("t4.b3", 32'hB3333333, 64'h500C, 64'd16);
    tick(); chk("t4.en_done", 64'(bus.enable_o), 64'd0);

    // 5: flush on slot 1 with a line offered
    offer(LA, 64'h6000);
    tick(); chk_issue("t5.s0", 32'hA0000000, 64'h6000, 64'd17);
    offer(LB, 64'h7000);
    tick(); chk_issue("t5.s1", 32'hA1111111, 64'h6004, 64'd18);
    flush = 1'b1;
    #1 chk("t5.ready_flush", 64'(bus.lineReady_o), 64'd0);
    tick();
    flush = 1'b0;
    bus.lineValid_i = 1'b0;
    chk("t5.en_after", 64'(bus.enable_o), 64'd0);
    chk("t5.id_after", 64'(bus.instructionMajId_o), 64'd18);
    tick(); chk("t5.not_taken", 64'(bus.enable_o), 64'd0);
    offer(LB, 64'h7000);
    tick();
    bus.lineValid_i = 1'b0;
    chk_issue("t5.next", 32'hB0000000, 64'h7000, 64'd18);

    // 6: asynchronous reset mid-line
    tick(); chk_issue("t6.s1", 32'hB1111111, 64'h7004, 64'd19);
    #3 rst_n = 1'b0;
    #1;
    chk("t6.en",   64'(bus.enable_o), 64'd0);
    chk("t6.id",   64'(bus.instructionMajId_o), 64'd0);
    chk("t6.addr", 64'(bus.instructionAddress_o), 64'd0);
    #2 rst_n = 1'b1;
    #1 chk("t6.ready", 64'(bus.lineReady_o), 64'd1);
    tick(); chk("t6.en_idle", 64'(bus.enable_o), 64'd0);

    // Last slot start issues exactly one instruction
    offer(L1, 64'h900C);
    tick();
    bus.lineValid_i = 1'b0;
    chk_issue("ls.s3", 32'h60000000, 64'h900C, 64'd0);
    tick(); chk("ls.en_done", 64'(bus.enable_o), 64'd0);

`ifdef FETCH_LE_SWAP_EN
    // 7: byte-reversed issue
    bus.littleEndian_i = 1'b1;
    offer({32'h78563412, 32'h0, 32'h0, 32'h0}, 64'h8000);
    tick();
    bus.lineValid_i = 1'b0;
    bus.littleEndian_i = 1'b0;
    chk_issue("t7.le", 32'h12345678, 64'h8000, 64'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
